// File: rtl/rom_load_pkg.sv
// Shared types and constants for the cartridge ROM load path.
`default_nettype none
package rom_load_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    ISSUE    = 3'd2,
    WAIT_ACK = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam int LINE_BYTES = 8;
  localparam int LANES      = 4;
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int CSUM_START = 'h200;

  // File bytes arrive little-endian per word; the DDRAM image is big-endian.
  function automatic logic [15:0] swap16(input logic [15:0] d);
    return {d[7:0], d[15:8]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rom_line_packer.sv
// rom_line_packer: packs 16-bit ioctl words into 64-bit DDRAM lines with byte enables.
// Optional checksum output enabled by defining ROM_CHECKSUM_EN.
`default_nettype none
module rom_line_packer
  import rom_load_pkg::*;
#(
  parameter int AW = 25
) (
  input  logic          clk_sys,
  input  logic          RESET_N,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [15:0]   ioctl_data,
  output logic          ioctl_wait,
  output logic [AW-1:0] wr_addr,
  output logic [63:0]   wr_data,
  output logic [7:0]    wr_be,
  output logic          wr_req,
  input  logic          wr_ack,
  output logic [AW-1:0] rom_size,
  output logic          load_done
`ifdef ROM_CHECKSUM_EN
  ,
  output logic [15:0]   checksum
`endif
);

  localparam int LW = AW - OFF_W;

  state_t          r_state, w_state_nxt;
  logic            r_dl_d, r_start_pend, r_final;
  logic            r_hold_valid;
  logic [AW-1:1]   r_hold_addr;
  logic [15:0]     r_hold_data;
  logic [63:0]     r_buf_data;
  logic [7:0]      r_buf_be;
  logic [LW-1:0]   r_buf_line;

  logic            w_rise, w_capture, w_acked, w_buf_empty, w_same_line, w_lane_last;
  logic [1:0]      w_lane;
  logic [LW-1:0]   w_hold_line;
  logic [63:0]     w_merge_data;
  logic [7:0]      w_merge_be;
  logic [AW-1:0]   w_size_cand, w_size_base;
  logic            w_start, w_merge, w_issue, w_ack_done, w_final_set, w_load_done;

  assign w_rise      = ioctl_download & ~r_dl_d;
  assign w_capture   = ioctl_download & ioctl_wr & ~r_hold_valid;
  assign w_acked     = (wr_ack == wr_req);
  assign w_lane      = r_hold_addr[2:1];
  assign w_hold_line = r_hold_addr[AW-1:OFF_W];
  assign w_buf_empty = (r_buf_be == 8'h00);
  assign w_same_line = (w_hold_line == r_buf_line);
  assign w_lane_last = (w_lane == 2'(LANES - 1));
  assign w_size_cand = ioctl_addr + AW'(2);
  assign w_size_base = w_start ? '0 : rom_size;

  always_comb begin
    w_merge_data = r_buf_data;
    w_merge_data[{w_lane, 4'b0000} +: 16] = swap16(r_hold_data);
    w_merge_be = r_buf_be | (8'b0000_0011 << {w_lane, 1'b0});
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_merge     = 1'b0;
    w_issue     = 1'b0;
    w_ack_done  = 1'b0;
    w_final_set = 1'b0;
    w_load_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise || r_start_pend) begin
          w_start     = 1'b1;
          w_state_nxt = FILL;
        end
      end
      FILL: begin
        // A held word is always merged before the end of download is acted on.
        if (r_hold_valid) begin
          if (w_buf_empty || w_same_line) begin
            w_merge = 1'b1;
            if (w_lane_last) w_state_nxt = ISSUE;
          end else begin
            w_state_nxt = ISSUE;
          end
        end else if (!ioctl_download) begin
          if (w_buf_empty) begin
            w_state_nxt = DONE;
          end else begin
            w_final_set = 1'b1;
            w_state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        w_issue     = 1'b1;
        w_state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (w_acked) begin
          w_ack_done = 1'b1;
          if (r_final) begin
            w_state_nxt = DONE;
          end else begin
            w_start     = r_start_pend;
            w_state_nxt = FILL;
          end
        end
      end
      DONE: begin
        w_load_done = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= IDLE;
      r_dl_d       <= 1'b0;
      r_start_pend <= 1'b0;
      r_final      <= 1'b0;
      r_hold_valid <= 1'b0;
      r_hold_addr  <= '0;
      r_hold_data  <= '0;
      r_buf_data   <= '0;
      r_buf_be     <= '0;
      r_buf_line   <= '0;
      ioctl_wait   <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      wr_be        <= '0;
      wr_req       <= 1'b0;
      rom_size     <= '0;
      load_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dl_d    <= ioctl_download;
      load_done <= w_load_done;

      if (w_start)                          r_start_pend <= 1'b0;
      else if (w_rise && r_state != IDLE)   r_start_pend <= 1'b1;

      if (w_start || w_load_done) r_final <= 1'b0;
      else if (w_final_set)       r_final <= 1'b1;

      if (w_capture) begin
        r_hold_valid <= 1'b1;
        r_hold_addr  <= ioctl_addr[AW-1:1];
        r_hold_data  <= ioctl_data;
      end else if (w_merge) begin
        r_hold_valid <= 1'b0;
      end

      if (w_start || w_ack_done) begin
        r_buf_data <= '0;
        r_buf_be   <= '0;
      end else if (w_merge) begin
        r_buf_data <= w_merge_data;
        r_buf_be   <= w_merge_be;
        r_buf_line <= w_hold_line;
      end

      // Wait stays up across a full line until its ack, and past the ack if a word is still held.
      if (w_capture)                    ioctl_wait <= 1'b1;
      else if (w_merge && !w_lane_last) ioctl_wait <= 1'b0;
      else if (w_ack_done)              ioctl_wait <= r_hold_valid;

      if (w_issue) begin
        wr_addr <= {r_buf_line, {OFF_W{1'b0}}};
        wr_data <= r_buf_data;
        wr_be   <= r_buf_be;
        wr_req  <= ~wr_req;
      end

      if (w_capture)    rom_size <= (w_size_cand > w_size_base) ? w_size_cand : w_size_base;
      else if (w_start) rom_size <= '0;
    end
  end

`ifdef ROM_CHECKSUM_EN
  logic [15:0] w_csum_base;
  assign w_csum_base = w_start ? 16'h0000 : checksum;

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      checksum <= '0;
    end else if (w_capture && ioctl_addr >= AW'(CSUM_START)) begin
      checksum <= w_csum_base + swap16(ioctl_data);
    end else if (w_start) begin
      checksum <= '0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rom_line_packer.sv
// Self-checking bench for rom_line_packer: single-word vector table plus multi-cycle sequences.
`default_nettype none
module tb_rom_line_packer;

  localparam int AW = 25;

  logic          clk_sys = 1'b0;
  logic          RESET_N = 1'b0;
  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [AW-1:0] ioctl_addr = '0;
  logic [15:0]   ioctl_data = '0;
  logic          ioctl_wait;
  logic [AW-1:0] wr_addr;
  logic [63:0]   wr_data;
  logic [7:0]    wr_be;
  logic          wr_req;
  logic          wr_ack = 1'b0;
  logic [AW-1:0] rom_size;
  logic          load_done;
`ifdef ROM_CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  rom_line_packer #(.AW(AW)) dut (
    .clk_sys        (clk_sys),
    .RESET_N        (RESET_N),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_data     (ioctl_data),
    .ioctl_wait     (ioctl_wait),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_be          (wr_be),
    .wr_req         (wr_req),
    .wr_ack         (wr_ack),
    .rom_size       (rom_size),
    .load_done      (load_done)
`ifdef ROM_CHECKSUM_EN
    ,
    .checksum       (checksum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [AW-1:0] a;
    logic [63:0]   d;
    logic [7:0]    be;
  } line_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic [AW-1:0] exp_addr;
    logic [63:0]   exp_data;
    logic [7:0]    exp_be;
    logic [AW-1:0] exp_size;
  } vec_t;

  line_t lq[$];
  int    total = 0;
  int    bad = 0;
  int    ack_delay = 0;
  int    ack_cnt = 0;
  logic  prev_req = 1'b0;
  int    done_qsize = -1;

  // DDRAM model: acknowledges each toggle after ack_delay extra cycles; logs issued lines.
  always @(negedge clk_sys) begin
    if (!RESET_N) begin
      wr_ack   = 1'b0;
      ack_cnt  = 0;
      prev_req = 1'b0;
    end else begin
      if (wr_req != prev_req) begin
        lq.push_back('{a: wr_addr, d: wr_data, be: wr_be});
        prev_req = wr_req;
      end
      if (wr_req != wr_ack) begin
        if (ack_cnt >= ack_delay) begin
          wr_ack  = wr_req;
          ack_cnt = 0;
        end else begin
          ack_cnt++;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_dl();
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic end_dl();
    @(negedge clk_sys);
    ioctl_download = 1'b0;
  endtask

  task automatic send_word(input logic [AW-1:0] a, input logic [15:0] d);
    int n = 0;
    @(negedge clk_sys);
    while (ioctl_wait && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= 200) check("send_wait_timeout", 64'(n), 64'd0);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_data = d;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!load_done && n < 400) begin
      @(negedge clk_sys);
      n++;
    end
    if (!load_done) begin
      check(name, 64'd0, 64'd1);
      done_qsize = -1;
    end else begin
      done_qsize = lq.size();
    end
  endtask

  task automatic check_line(input string name, input int idx, input logic [AW-1:0] a,
                            input logic [63:0] d, input logic [7:0] be);
    if (idx < lq.size()) begin
      check({name, "_addr"}, 64'(lq[idx].a), 64'(a));
      check({name, "_data"}, lq[idx].d, d);
      check({name, "_be"}, 64'(lq[idx].be), 64'(be));
    end else begin
      check({name, "_missing"}, 64'(lq.size()), 64'(idx + 1));
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_wait"}, 64'(ioctl_wait), 64'd0);
    check({name, "_wr_addr"}, 64'(wr_addr), 64'd0);
    check({name, "_wr_data"}, wr_data, 64'd0);
    check({name, "_wr_be"}, 64'(wr_be), 64'd0);
    check({name, "_wr_req"}, 64'(wr_req), 64'd0);
    check({name, "_rom_size"}, 64'(rom_size), 64'd0);
    check({name, "_load_done"}, 64'(load_done), 64'd0);
  endtask

  vec_t vecs[5];

  initial begin
    int wcnt;

    vecs[0] = '{addr: 25'h000_0008, data: 16'h1234, exp_addr: 25'h000_0008,
                exp_data: 64'h0000_0000_0000_3412, exp_be: 8'h03, exp_size: 25'h000_000A};
    vecs[1] = '{addr: 25'h000_000A, data: 16'hABCD, exp_addr: 25'h000_0008,
                exp_data: 64'h0000_0000_CDAB_0000, exp_be: 8'h0C, exp_size: 25'h000_000C};
    vecs[2] = '{addr: 25'h000_0014, data: 16'h5A5A, exp_addr: 25'h000_0010,
                exp_data: 64'h0000_5A5A_0000_0000, exp_be: 8'h30, exp_size: 25'h000_0016};
    vecs[3] = '{addr: 25'h000_001E, data: 16'h0102, exp_addr: 25'h000_0018,
                exp_data: 64'h0201_0000_0000_0000, exp_be: 8'hC0, exp_size: 25'h000_0020};
    vecs[4] = '{addr: 25'h1FF_FFF6, data: 16'hFFEE, exp_addr: 25'h1FF_FFF0,
                exp_data: 64'hEEFF_0000_0000_0000, exp_be: 8'hC0, exp_size: 25'h1FF_FFF8};

    #2;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk_sys);
    RESET_N = 1'b1;

    // One word per download: lane placement, byte swap, partial BE, rom_size
    for (int i = 0; i < 5; i++) begin
      lq.delete();
      start_dl();
      send_word(vecs[i].addr, vecs[i].data);
      end_dl();
      wait_done($sformatf("vec%0d_done_timeout", i));
      check($sformatf("vec%0d_nlines", i), 64'(lq.size()), 64'd1);
      check_line($sformatf("vec%0d", i), 0, vecs[i].exp_addr, vecs[i].exp_data, vecs[i].exp_be);
      check($sformatf("vec%0d_rom_size", i), 64'(rom_size), 64'(vecs[i].exp_size));
    end

    // Full line of four words
    lq.delete();
    start_dl();
    send_word(25'h0, 16'h3412);
    send_word(25'h2, 16'h7856);
    send_word(25'h4, 16'hBC9A);
    send_word(25'h6, 16'hF0DE);
    end_dl();
    wait_done("full_done_timeout");
    check("full_nlines", 64'(lq.size()), 64'd1);
    check_line("full", 0, 25'h0, 64'hDEF0_9ABC_5678_1234, 8'hFF);
    check("full_rom_size", 64'(rom_size), 64'h8);

    // Line change with a held word, then final flush
    lq.delete();
    start_dl();
    send_word(25'h08, 16'hA1B2);
    send_word(25'h20, 16'hC3D4);
    end_dl();
    wait_done("two_done_timeout");
    check("two_lines_at_done", 64'(done_qsize), 64'd2);
    check_line("two_l0", 0, 25'h08, 64'h0000_0000_0000_B2A1, 8'h03);
    check_line("two_l1", 1, 25'h20, 64'h0000_0000_0000_D4C3, 8'h03);
    check("two_rom_size", 64'(rom_size), 64'h22);

    // Write strobe while download is low is ignored
    lq.delete();
    @(negedge clk_sys);
    ioctl_wr = 1'b1; ioctl_addr = 25'h100; ioctl_data = 16'h5555;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    check("nodl_wait0", 64'(ioctl_wait), 64'd0);
    repeat (4) @(negedge clk_sys);
    check("nodl_wait1", 64'(ioctl_wait), 64'd0);
    check("nodl_nlines", 64'(lq.size()), 64'd0);
    check("nodl_rom_size", 64'(rom_size), 64'h22);

    // Slow ack: wait held for the whole window, a single toggle
    lq.delete();
    ack_delay = 20;
    start_dl();
    send_word(25'h40, 16'h1111);
    send_word(25'h42, 16'h2222);
    send_word(25'h44, 16'h3333);
    send_word(25'h46, 16'h4444);
    wcnt = 0;
    while (ioctl_wait && wcnt < 100) begin
      wcnt++;
      @(negedge clk_sys);
    end
    total++;
    if (wcnt < 21 || wcnt > 25) begin
      bad++;
      $display("FAIL slow_wait_cycles: got %0d expected 21..25", wcnt);
    end
    check("slow_toggles_in_window", 64'(lq.size()), 64'd1);
    send_word(25'h48, 16'h5566);
    end_dl();
    wait_done("slow_done_timeout");
    check("slow_nlines", 64'(lq.size()), 64'd2);
    check_line("slow_l0", 0, 25'h40, 64'h4444_3333_2222_1111, 8'hFF);
    check_line("slow_l1", 1, 25'h48, 64'h0000_0000_0000_6655, 8'h03);

    // Reset in the middle of WAIT_ACK, then a fresh download
    lq.delete();
    ack_delay = 50;
    start_dl();
    send_word(25'h60, 16'hAAAA);
    send_word(25'h62, 16'hBBBB);
    send_word(25'h64, 16'hCCCC);
    send_word(25'h66, 16'hDDDD);
    repeat (5) @(negedge clk_sys);
    check("mid_wr_req_pending", 64'(wr_req != wr_ack), 64'd1);
    RESET_N = 1'b0;
    ioctl_download = 1'b0;
    wr_ack = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(negedge clk_sys);
    RESET_N = 1'b1;
    ack_delay = 0;
    lq.delete();
    start_dl();
    send_word(25'h2, 16'h1234);
    end_dl();
    wait_done("post_rst_done_timeout");
    check("post_rst_nlines", 64'(lq.size()), 64'd1);
    check_line("post_rst", 0, 25'h0, 64'h0000_0000_3412_0000, 8'h0C);
    check("post_rst_rom_size", 64'(rom_size), 64'h4);

`ifdef ROM_CHECKSUM_EN
    lq.delete();
    start_dl();
    send_word(25'h1FE, 16'h0100);
    send_word(25'h200, 16'h0100);
    send_word(25'h202, 16'h0200);
    end_dl();
    wait_done("csum_done_timeout");
    check("csum_value", 64'(checksum), 64'h0003);
`endif

    repeat (3) @(negedge clk_sys);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
